// File: rtl/cal_pkg.sv
// Shared types and helpers for the DC-offset calibrator family.
package cal_pkg;

  localparam int unsigned CAL_W_DEF        = 24;
  localparam int unsigned CAL_NCH_DEF      = 4;
  localparam int unsigned CAL_MAX_LOG2_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } cal_state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Half-LSB rounding term for a right shift by l; zero when nothing is shifted out.
  function automatic longint unsigned round_const(input int unsigned l);
    return (l == 0) ? 64'd0 : (64'd1 << (l - 1));
  endfunction

endpackage

// File: rtl/cal_round_shift.sv
// Round-to-nearest arithmetic shift of an accumulator down to sample width.
module cal_round_shift
  import cal_pkg::*;
#(
  parameter int unsigned W  = 24,
  parameter int unsigned AW = 34,
  parameter int unsigned LW = 4
) (
  input  logic signed [AW-1:0] acc,
  input  logic        [LW-1:0] l,
  output logic signed [W-1:0]  res_c
);

  logic signed [AW-1:0] sum_c;

  // Headroom in the accumulator guarantees the rounding add cannot wrap.
  always_comb begin
    sum_c = acc + $signed(AW'(round_const(32'(l))));
    res_c = W'(sum_c >>> l);
  end

endmodule

// File: rtl/cal_offset_mc.sv
// Multi-channel DC-offset calibrator: averages 2^L tagged samples per channel
// and publishes rounded per-channel offsets.
module cal_offset_mc
  import cal_pkg::*;
#(
  parameter int unsigned W        = CAL_W_DEF,
  parameter int unsigned NCH      = CAL_NCH_DEF,
  parameter int unsigned MAX_LOG2 = CAL_MAX_LOG2_DEF,
  localparam int unsigned CHW     = clog2_min1(NCH),
  localparam int unsigned LW      = clog2_min1(MAX_LOG2 + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                cont,
  input  logic [LW-1:0]       log2_n,
  input  logic signed [W-1:0] din,
  input  logic [CHW-1:0]      din_ch,
  input  logic                din_valid,
  output logic                busy,
  output logic                done,
  output logic [NCH*W-1:0]    offset_out,
  output logic [NCH-1:0]      offset_valid
);

  localparam int unsigned AW = W + MAX_LOG2;
  localparam int unsigned CW = MAX_LOG2 + 1;
  localparam int unsigned KW = clog2_min1(NCH + 1);

  cal_state_t           state_q, state_d;
  logic [LW-1:0]        l_q;
  logic [KW-1:0]        div_k_q;
  logic signed [AW-1:0] acc_q [NCH];
  logic [CW-1:0]        cnt_q [NCH];

  logic [CW-1:0]        quota_c;
  logic [LW-1:0]        l_clamp_c;
  logic [NCH-1:0]       hit_c;
  logic                 all_full_c;
  logic                 clear_c;
  logic                 wr_c;
  logic signed [AW-1:0] acc_sel_c;
  logic signed [W-1:0]  rs_c;

  // Next state, per-channel accept and DIV control.
  always_comb begin
    state_d    = state_q;
    quota_c    = CW'(1) << l_q;
    l_clamp_c  = (log2_n > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : log2_n;
    hit_c      = '0;
    all_full_c = 1'b1;
    acc_sel_c  = '0;
    for (int k = 0; k < NCH; k++) begin
      hit_c[k] = (state_q == ST_RUN) && din_valid && (din_ch == CHW'(k)) &&
                 (cnt_q[k] != quota_c);
      if ((cnt_q[k] + CW'(hit_c[k])) != quota_c) all_full_c = 1'b0;
      if (div_k_q == KW'(k)) acc_sel_c = acc_q[k];
    end

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (all_full_c) state_d = ST_DIV;
      ST_DIV:  if (div_k_q == KW'(NCH)) state_d = ST_DONE;
      ST_DONE: state_d = cont ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;

    clear_c = abort || (state_q == ST_IDLE) || (state_q == ST_DONE);
    // Index NCH is a drain cycle with no write before DONE.
    wr_c    = (state_q == ST_DIV) && !abort && (div_k_q < KW'(NCH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      l_q     <= '0;
      div_k_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_RUN) || (state_d == ST_DIV);
      done    <= (state_d == ST_DONE);
      div_k_q <= ((state_q == ST_DIV) && (state_d == ST_DIV)) ? div_k_q + KW'(1) : '0;
      if ((state_q == ST_IDLE) && start && !abort) l_q <= l_clamp_c;
    end
  end

  // Accumulator and sample-count banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        acc_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (clear_c) begin
          acc_q[k] <= '0;
          cnt_q[k] <= '0;
        end else if (hit_c[k]) begin
          acc_q[k] <= acc_q[k] + AW'(din);
          cnt_q[k] <= cnt_q[k] + CW'(1);
        end
      end
    end
  end

  cal_round_shift #(
    .W  (W),
    .AW (AW),
    .LW (LW)
  ) u_round_shift (
    .acc   (acc_sel_c),
    .l     (l_q),
    .res_c (rs_c)
  );

  // Published offsets survive abort; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_out   <= '0;
      offset_valid <= '0;
    end else if (wr_c) begin
      for (int k = 0; k < NCH; k++) begin
        if (div_k_q == KW'(k)) begin
          offset_out[k*W +: W] <= rs_c;
          offset_valid[k]      <= 1'b1;
        end
      end
    end
  end

endmodule
